cpu_lsu: RTL
============

CPU_LSU -- requirements
Module: cpu_lsu

Interface
REQ-001 Parameters: none; address and data widths are fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  core presents a memory operation.
REQ-005 req_ready  output  1  LSU can accept; handshake occurs when req_valid & req_ready.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 mem_valid  output  1  bus request; held until mem_ready.
REQ-011 mem_ready  input  1  bus completes the access on this cycle.
REQ-012 mem_addr  output  32  word-aligned bus address (bits [1:0] = 0).
REQ-013 mem_we  output  1  bus write.
REQ-014 mem_wstrb  output  4  byte-write enables.
REQ-015 mem_wdata  output  32  lane-aligned write data.
REQ-016 mem_rdata  input  32  read data, valid when mem_valid & mem_ready.
REQ-017 resp_valid  output  1  one-cycle completion pulse.
REQ-018 resp_data  output  32  extended load result; 0 for stores.
REQ-019 resp_fault  output  1  misaligned-access fault, qualified by resp_valid.

Function
REQ-020 States: IDLE, ACC0, ACC1, RESP; req_ready = 1 only in IDLE.
REQ-021 On handshake, LSU registers we/funct3/addr/wdata and moves to ACC0; mem_valid rises the following cycle.
REQ-022 ACC0 drives mem_addr = {addr[31:2],2'b00}; state stays while !mem_ready.
REQ-023 Store lanes: wstrb = size mask (B 0001, H 0011, W 1111) << addr[1:0], wdata = wdata << 8*addr[1:0], both computed over 8 bytes / 64 bits; low half to ACC0, high half to ACC1.
REQ-024 An access spans two words when the upper 4 strobe bits are non-zero; then ACC0 + mem_ready -> ACC1, else -> RESP.
REQ-025 ACC1 drives mem_addr = ACC0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); ACC1 + mem_ready -> RESP.
REQ-026 Loads capture mem_rdata on each completing beat; result = {beat1,beat0} >> 8*addr[1:0], low 32 bits; beat1 = 0 when single-beat.
REQ-027 Result is sign- or zero-extended per funct3 (B/H sign, BU/HU zero, W none).
REQ-028 RESP asserts resp_valid for exactly one cycle, then -> IDLE; aligned latency handshake-to-resp_valid = 2 cycles + bus wait cycles.
REQ-029 mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata are stable while mem_valid & !mem_ready.
REQ-030 Invalid funct3 (011, 110, 111; 100/101 with we) completes with resp_fault = 1, no bus access.
REQ-031 A new request is accepted no earlier than the cycle after resp_valid (no overlap).

Reset
REQ-032 When rst_n = 0 at a clock edge: state = IDLE; mem_valid, resp_valid, resp_fault = 0; resp_data, mem_addr, mem_wdata, mem_wstrb = 0; mem_we = 0.
REQ-033 Reset mid-access (ACC0/ACC1) abandons the transaction with no response; mem_valid deasserts the next cycle.

Configuration
REQ-034 Macro CPU_LSU_MISALIGNED_EN: defined -> two-beat split per REQ-024..026.
REQ-035 Undefined -> any access needing two words produces no bus access, resp_valid in RESP with resp_fault = 1, resp_data = 0 (latency 2 cycles).

Structure
REQ-036 Package cpu_pkg holds funct3 load/store constants and the LSU state encoding.
REQ-037 Sign/zero extension is performed by an instance of the existing cpu_data_extend sub-module; no other sub-modules.

Verification
REQ-038 LW 0x100, mem_rdata 0xDEADBEEF, mem_ready immediate -> one beat addr 0x100, resp_data 0xDEADBEEF at cycle +2.
REQ-039 LB 0x103, rdata 0x80FFFFFF -> resp_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-040 SH 0x102 wdata 0x1234 -> mem_addr 0x100, wstrb 1100, wdata 0x12340000, one beat.
REQ-041 MISALIGNED_EN: LW 0xFFFFFFFE, beats 0xAABBCCDD @0xFFFFFFFC then 0x11223344 @0x00000000 -> resp_data 0x3344AABB; undefined -> resp_fault 1, no mem_valid.
REQ-042 SW 0x101 wdata 0xA1B2C3D4, mem_ready held low 3 cycles -> outputs stable; beat0 wstrb 1110 wdata 0xB2C3D400, beat1 wstrb 0001 wdata 0x000000A1.
REQ-043 rst_n low during ACC1 -> IDLE, mem_valid 0 next cycle, no resp_valid; next request behaves normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU load/store path: funct3 encodings,
// LSU state encoding and small decode helpers.
package cpu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_ACC1 = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   // Byte mask of the access size before lane shifting; zero for illegal codes.
   function automatic logic [3:0] size_mask(input logic [2:0] funct3);
      logic [3:0] m;
      case (funct3)
         F3_B, F3_BU: m = 4'b0001;
         F3_H, F3_HU: m = 4'b0011;
         F3_W:        m = 4'b1111;
         default:     m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic funct3_ok(input logic we, input logic [2:0] funct3);
      logic ok;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/cpu_data_extend.sv
// Sign/zero extension of a right-aligned load result according to funct3.
module cpu_data_extend
   import cpu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = data_i;
      case (funct3_i)
         F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
         F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
         F3_BU:   data_o = {24'h000000, data_i[7:0]};
         F3_HU:   data_o = {16'h0000, data_i[15:0]};
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: one request at a time, word bus, up to two beats per access.
// Define CPU_LSU_MISALIGNED_EN to split word-crossing accesses; otherwise they fault.
module cpu_lsu
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_fault
);

   // Handshake: a request transfers on a rising edge where req_valid & req_ready;
   // a bus beat completes on a rising edge where mem_valid & mem_ready, and all
   // mem_* outputs hold steady until then.

   lsu_state_e  state_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic        fault_q;
   logic        two_q;
   logic [3:0]  wstrb_hi_q;
   logic [31:0] wdata_hi_q;
   logic [31:0] beat0_q;

   logic        mem_valid_q;
   logic [31:0] mem_addr_q;
   logic        mem_we_q;
   logic [3:0]  mem_wstrb_q;
   logic [31:0] mem_wdata_q;
   logic        resp_valid_q;
   logic [31:0] resp_data_q;
   logic        resp_fault_q;

   logic [7:0]  st_wstrb8_d;
   logic [63:0] st_wdata64_d;
   logic        need_two_d;
   logic        acc_fault_d;

   logic [31:0] ld_lo_d;
   logic [31:0] ld_hi_d;
   logic [31:0] ld_raw_d;
   logic [31:0] ld_ext_d;

   // Lane placement of the incoming request, spread across two bus words.
   always_comb begin
      st_wstrb8_d  = {4'b0000, size_mask(req_funct3)} << req_addr[1:0];
      st_wdata64_d = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
      need_two_d   = |st_wstrb8_d[7:4];
`ifdef CPU_LSU_MISALIGNED_EN
      acc_fault_d  = !funct3_ok(req_we, req_funct3);
`else
      acc_fault_d  = !funct3_ok(req_we, req_funct3) || need_two_d;
`endif
   end

   // Load alignment: the beat completing now joins the earlier beat, if any.
   always_comb begin
      ld_lo_d  = mem_rdata;
      ld_hi_d  = 32'h0;
      if (state_q == ST_ACC1) begin
         ld_lo_d = beat0_q;
         ld_hi_d = mem_rdata;
      end
      ld_raw_d = 32'({ld_hi_d, ld_lo_d} >> {off_q, 3'b000});
   end

   cpu_data_extend u_extend (
      .funct3_i (funct3_q),
      .data_i   (ld_raw_d),
      .data_o   (ld_ext_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         fault_q      <= 1'b0;
         two_q        <= 1'b0;
         wstrb_hi_q   <= 4'h0;
         wdata_hi_q   <= 32'h0;
         beat0_q      <= 32'h0;
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_we_q     <= 1'b0;
         mem_wstrb_q  <= 4'h0;
         mem_wdata_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'h0;
         resp_fault_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q        <= req_we;
                  funct3_q    <= req_funct3;
                  off_q       <= req_addr[1:0];
                  fault_q     <= acc_fault_d;
                  two_q       <= need_two_d;
                  wstrb_hi_q  <= req_we ? st_wstrb8_d[7:4] : 4'h0;
                  wdata_hi_q  <= req_we ? st_wdata64_d[63:32] : 32'h0;
                  mem_valid_q <= !acc_fault_d;
                  mem_addr_q  <= {req_addr[31:2], 2'b00};
                  mem_we_q    <= req_we;
                  mem_wstrb_q <= req_we ? st_wstrb8_d[3:0] : 4'h0;
                  mem_wdata_q <= req_we ? st_wdata64_d[31:0] : 32'h0;
                  state_q     <= ST_ACC0;
               end
            end
            ST_ACC0: begin
               if (fault_q) begin
                  resp_valid_q <= 1'b1;
                  resp_fault_q <= 1'b1;
                  resp_data_q  <= 32'h0;
                  state_q      <= ST_RESP;
               end else if (mem_ready) begin
                  beat0_q <= mem_rdata;
                  if (two_q) begin
                     mem_addr_q  <= mem_addr_q + 32'd4;
                     mem_wstrb_q <= wstrb_hi_q;
                     mem_wdata_q <= wdata_hi_q;
                     state_q     <= ST_ACC1;
                  end else begin
                     mem_valid_q  <= 1'b0;
                     resp_valid_q <= 1'b1;
                     resp_fault_q <= 1'b0;
                     resp_data_q  <= we_q ? 32'h0 : ld_ext_d;
                     state_q      <= ST_RESP;
                  end
               end
            end
            ST_ACC1: begin
               if (mem_ready) begin
                  mem_valid_q  <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_fault_q <= 1'b0;
                  resp_data_q  <= we_q ? 32'h0 : ld_ext_d;
                  state_q      <= ST_RESP;
               end
            end
            ST_RESP: begin
               resp_valid_q <= 1'b0;
               resp_fault_q <= 1'b0;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign mem_valid  = mem_valid_q;
   assign mem_addr   = mem_addr_q;
   assign mem_we     = mem_we_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_fault = resp_fault_q;

endmodule
